// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end.
// Contents:
//   XLEN          - instruction / address word width (16)
//   OPC_HLT       - opcode field value of the HLT instruction
//   INSTR_BUBBLE  - instruction value presented when no instruction is valid
//   fetch_state_e - fetch FSM states (RUN, HALT)
//   fq_entry_t    - prefetch queue entry {pc, instr}
//   is_hlt()      - opcode decode helper for HLT
package cpu_pkg;

    localparam int unsigned       XLEN         = 16;
    localparam logic [3:0]        OPC_HLT      = 4'hF;
    localparam logic [XLEN-1:0]   INSTR_BUBBLE = 16'h0000;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fq_entry_t;

    function automatic logic is_hlt(input logic [XLEN-1:0] ins);
        return ins[XLEN-1 -: 4] == OPC_HLT;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: circular buffer of DEPTH {pc, instr} entries.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   flush      - empties the queue; wins over push/pop in the same cycle
//   push       - write push_data at the tail
//   push_data  - entry to write
//   pop        - drop the head entry
//   head       - current head entry (valid when !empty)
//   full/empty - occupancy flags
//   count      - current occupancy
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fq_entry_t     push_data,
    input  logic          pop,
    output fq_entry_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    fq_entry_t     mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] wr_ptr_q;
    logic [CW-1:0] count_q;

    // DEPTH need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit with prefetch queue, branch redirect and HLT handling.
// Optional feature: define FETCH_BYPASS_EN to let a response that arrives while
// the queue is empty appear on instr in its return cycle (one cycle less latency).
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   stall               - IF_ID hold; head instruction does not advance
//   alt_pc_ctrl, alt_pc - redirect strobe and target word address
//   imem_re, imem_addr  - instruction memory read request / word address
//   imem_rdata          - read data, valid one cycle after imem_re
//   instr, pc           - instruction and its address presented to IF_ID
//   instr_vld           - instr/pc valid (0 = bubble)
//   hlt                 - processor halted
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned QDEPTH   = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        alt_pc_ctrl,
    input  logic [15:0] alt_pc,
    output logic        imem_re,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        instr_vld,
    output logic        hlt
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);

    fetch_state_e  state_q;
    logic [15:0]   fetch_pc_q;
    logic [15:0]   resp_pc_q;   // address of the read currently in flight
    logic          inflight_q;
    logic          drop_q;      // in-flight response belongs to a squashed path

    logic          run;
    logic          resp_vld;
    logic          bypass;
    logic          pop_any;
    logic          halt_enter;
    logic          q_push;
    logic          q_pop;
    logic          q_flush;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    logic [CW:0]   occ;
    fq_entry_t     q_head;
    fq_entry_t     q_wdata;

    assign run      = (state_q == FS_RUN) && !rst;
    assign resp_vld = run && inflight_q && !drop_q;

`ifdef FETCH_BYPASS_EN
    // A response arriving during a redirect is wrong-path; keep it off instr.
    assign bypass = resp_vld && q_empty && !alt_pc_ctrl;
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        instr     = INSTR_BUBBLE;
        pc        = fetch_pc_q;
        instr_vld = 1'b0;
        if (run) begin
            if (!q_empty) begin
                instr     = q_head.instr;
                pc        = q_head.pc;
                instr_vld = 1'b1;
            end else if (bypass) begin
                instr     = imem_rdata;
                pc        = resp_pc_q;
                instr_vld = 1'b1;
            end
        end
    end

    assign pop_any    = instr_vld && !stall;
    assign q_pop      = pop_any && !q_empty;
    // A bypassed response consumed this cycle never enters the queue.
    assign q_push     = resp_vld && !(bypass && !stall);
    assign halt_enter = pop_any && is_hlt(instr) && !alt_pc_ctrl;
    assign q_flush    = alt_pc_ctrl || halt_enter || (state_q == FS_HALT);
    assign q_wdata    = '{pc: resp_pc_q, instr: imem_rdata};

    // Slot freed by this cycle's pop counts as free: the response to a read
    // issued now lands next cycle, after the pop has taken effect.
    assign occ = {1'b0, q_count} + (CW+1)'(inflight_q) - (CW+1)'(pop_any);

    assign imem_re   = run && !(q_full && !pop_any) && (occ < (CW+1)'(QDEPTH));
    assign imem_addr = fetch_pc_q;
    assign hlt       = (state_q == FS_HALT) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FS_RUN;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            case (state_q)
                FS_RUN: begin
                    inflight_q <= imem_re;
                    resp_pc_q  <= fetch_pc_q;
                    drop_q     <= alt_pc_ctrl && imem_re;
                    if (alt_pc_ctrl)  fetch_pc_q <= alt_pc;
                    else if (imem_re) fetch_pc_q <= fetch_pc_q + 16'd1;
                    if (halt_enter)   state_q <= FS_HALT;
                end
                default: begin
                    inflight_q <= 1'b0;
                    drop_q     <= 1'b0;
                end
            endcase
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush),
        .push      (q_push),
        .push_data (q_wdata),
        .pop       (q_pop),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, prefetch queue entries (legal 2..8).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, first fetch address after reset.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port stall, input, 1, IF_ID hold request; head instruction must not advance.
REQ-006 SHALL have port alt_pc_ctrl, input, 1, taken branch/jump redirect strobe.
REQ-007 SHALL have port alt_pc, input, 16, redirect target (word address).
REQ-008 SHALL have port imem_re, output, 1, instruction memory read request.
REQ-009 SHALL have port imem_addr, output, 16, instruction memory word address.
REQ-010 SHALL have port imem_rdata, input, 16, read data valid exactly one cycle after imem_re.
REQ-011 SHALL have port instr, output, 16, instruction presented to IF_ID.
REQ-012 SHALL have port pc, output, 16, address of instr.
REQ-013 SHALL have port instr_vld, output, 1, instr/pc valid; 0 = bubble.
REQ-014 SHALL have port hlt, output, 1, processor halted.

Function
REQ-015 SHALL hold states RUN and HALT; the reset state is RUN.
REQ-016 In RUN, SHALL assert imem_re with imem_addr=fetch_pc whenever (queue occupancy + in-flight reads) < QDEPTH, then fetch_pc <= fetch_pc+1 (16-bit wrap, 16'hFFFF -> 16'h0000).
REQ-017 SHALL write each returned imem_rdata with its address into the queue tail in the return cycle unless that response is marked dropped.
REQ-018 SHALL drive instr/pc from queue head with instr_vld=1 when non-empty; when empty, instr=16'h0000, pc=fetch_pc, instr_vld=0.
REQ-019 SHALL pop head on instr_vld & ~stall; stall holds instr, pc, instr_vld unchanged.
REQ-020 Full queue SHALL suppress imem_re; a push and a pop in the same cycle SHALL leave occupancy unchanged.
REQ-021 On alt_pc_ctrl in RUN: flush queue, mark any in-flight read dropped, fetch_pc <= alt_pc; imem_re with imem_addr=alt_pc next cycle. Redirect overrides stall.
REQ-022 Redirect at cycle N SHALL force instr_vld=0 in N+1 and N+2; first target instruction valid at N+3 (N+2 with bypass, REQ-029).
REQ-023 HLT (instr[15:12]==4'hF) popped (instr_vld & ~stall) in RUN SHALL enter HALT next cycle, unless alt_pc_ctrl is asserted in the same cycle (redirect wins; stay RUN).
REQ-024 In HALT: hlt=1, imem_re=0, instr_vld=0, queue empty, in-flight data dropped; alt_pc_ctrl and stall ignored; only rst exits.
REQ-025 A stalled HLT at head SHALL NOT cause halt until popped.

Reset
REQ-026 While rst=1: state RUN, fetch_pc=RESET_PC, queue empty, drop flag clear, imem_re=0, instr_vld=0, instr=16'h0000, hlt=0.
REQ-027 First cycle after rst deasserts: imem_re=1, imem_addr=RESET_PC.
REQ-028 rst asserted mid-operation (including HALT or with read in flight) SHALL discard all state; stale imem_rdata ignored.

Configuration
REQ-029 Macro FETCH_BYPASS_EN defined: response arriving while queue is empty SHALL appear on instr with instr_vld=1 in the return cycle (popped if ~stall, else enqueued).
REQ-030 FETCH_BYPASS_EN undefined: every response SHALL enter the queue first; one extra cycle of fetch latency.

Structure
REQ-031 Shared package cpu_pkg SHALL hold OPC_HLT (4'hF), INSTR_BUBBLE (16'h0000), word width 16 and the fetch state enum.
REQ-032 Queue SHALL be sub-module fetch_queue (QDEPTH entries of {pc,instr}, push/pop/flush, full/empty).

Verification
REQ-033 Reset release, RESET_PC=0, stall=0, no bypass: imem_addr 0,1,2 in cycles 1,2,3; instr_vld first at cycle 3 with pc=0.
REQ-034 stall held 4 cycles with queue full: imem_re=0, instr/pc constant; on release, consecutive pcs without gap or duplicate.
REQ-035 alt_pc_ctrl=1, alt_pc=16'h0040 with read in flight: old response discarded; next valid pc=16'h0040 at N+3 (N+2 with FETCH_BYPASS_EN).
REQ-036 HLT at pc 5 popped: hlt=1 next cycle, imem_re=0 thereafter; later alt_pc_ctrl has no effect; rst returns to RUN at RESET_PC.
REQ-037 HLT popped same cycle as alt_pc_ctrl=1 to 16'h0010: hlt stays 0, next valid pc=16'h0010.
REQ-038 fetch_pc=16'hFFFF: next imem_addr=16'h0000.
